a2d_scan_sched: RTL



---
 rtl/a2d_scan_sched.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/a2d_scan_sched.sv
// Scan/single-shot sequencer in front of A2D_intf: walks the enabled line-sensor
// channels in ascending order into a register file and slots host single-shots between scans.
module a2d_scan_sched #(
   parameter int NUM_CH  = 8,
   parameter int GAP     = 4,
   parameter int TIMEOUT = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scan_en,
   input  logic        cont,
   input  logic [7:0]  ch_mask,
   input  logic        ss_req,
   input  logic [2:0]  ss_ch,
   output logic        ss_ack,
   output logic [11:0] ss_res,
   output logic        strt_cnv,
   output logic [2:0]  chnnl,
   input  logic        cnv_cmplt,
   input  logic [11:0] res,
   input  logic [2:0]  rd_ch,
   output logic [11:0] rd_data,
   output logic        frame_done,
   output logic        busy,
   output logic        tmo_err
);
   typedef enum logic [2:0] {S_IDLE, S_GAP, S_START, S_WAIT, S_STORE} state_e;

   localparam logic [7:0] CH_VALID = 8'(8'hFF >> (8 - NUM_CH));
   localparam int         GW       = $clog2(GAP + 1);
   localparam int         TW       = $clog2(TIMEOUT + 1);

   // Returns {found, index} of the lowest set bit of m at or above position from.
   function automatic logic [3:0] first_at_or_above(input logic [7:0] m, input logic [3:0] from);
      logic [3:0] r;
      r = 4'h0;
      for (int i = 7; i >= 0; i--)
         if (m[i] && (i >= int'(from))) r = {1'b1, 3'(i)};
      return r;
   endfunction

   state_e        state_q, state_d;
   logic [7:0]    mask_q, mask_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [2:0]    cur_ch_q, cur_ch_d;
   logic          cur_ss_q, cur_ss_d;
   logic          frame_act_q, frame_act_d;
   logic          hold_q, hold_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          skip_q, skip_d;
   logic          tmo_err_q, tmo_err_d;
   logic [11:0]   res_q, res_d;
   logic [11:0]   ss_res_q, ss_res_d;
   logic          cnv_cmplt_q;
   logic [11:0]   rf_q [8];
   logic          rf_we;
   logic          last_ch;
   logic [3:0]    lowest;
   logic [3:0]    nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         ptr_q       <= '0;
         cur_ch_q    <= '0;
         cur_ss_q    <= 1'b0;
         frame_act_q <= 1'b0;
         hold_q      <= 1'b0;
         gap_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         skip_q      <= 1'b0;
         tmo_err_q   <= 1'b0;
         res_q       <= '0;
         ss_res_q    <= '0;
         cnv_cmplt_q <= 1'b0;
         // NOTE: the register file is small and must read 0 after reset, so it is reset like any flop.
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         ptr_q       <= ptr_d;
         cur_ch_q    <= cur_ch_d;
         cur_ss_q    <= cur_ss_d;
         frame_act_q <= frame_act_d;
         hold_q      <= hold_d;
         gap_cnt_q   <= gap_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         skip_q      <= skip_d;
         tmo_err_q   <= tmo_err_d;
         res_q       <= res_d;
         ss_res_q    <= ss_res_d;
         cnv_cmplt_q <= cnv_cmplt;
         if (rf_we) rf_q[ptr_q] <= res_q;
      end
   end

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no latch is inferred.
      state_d     = state_q;
      mask_d      = mask_q;
      ptr_d       = ptr_q;
      cur_ch_d    = cur_ch_q;
      cur_ss_d    = cur_ss_q;
      frame_act_d = frame_act_q;
      hold_d      = hold_q && scan_en && !cont;
      gap_cnt_d   = gap_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      skip_d      = skip_q;
      tmo_err_d   = tmo_err_q;
      res_d       = res_q;
      ss_res_d    = ss_res_q;
      rf_we       = 1'b0;
      last_ch     = 1'b0;
      nxt         = 4'h0;
      lowest      = first_at_or_above(ch_mask & CH_VALID, 4'd0);
      case (state_q)
         S_IDLE: begin
            gap_cnt_d = '0;
            if (ss_req) begin
               cur_ss_d = 1'b1;
               cur_ch_d = ss_ch;
               state_d  = S_GAP;
            end else if (scan_en && lowest[3] && !hold_q) begin
               mask_d      = ch_mask & CH_VALID;
               ptr_d       = lowest[2:0];
               cur_ch_d    = lowest[2:0];
               cur_ss_d    = 1'b0;
               frame_act_d = 1'b1;
               state_d     = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GW'(GAP - 1)) state_d = S_START;
            else                           gap_cnt_d = gap_cnt_q + 1'b1;
         end
         S_START: begin
            tmo_cnt_d = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (cnv_cmplt && !cnv_cmplt_q) begin
               res_d   = res;
               skip_d  = 1'b0;
               state_d = S_STORE;
               if (cur_ss_q) ss_res_d = res;
            end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
               skip_d    = 1'b1;
               tmo_err_d = 1'b1;
               state_d   = S_STORE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         S_STORE: begin
            gap_cnt_d = '0;
            if (cur_ss_q) begin
               frame_act_d = frame_act_q && scan_en;
            end else begin
               rf_we   = !skip_q;
               nxt     = first_at_or_above(mask_q, {1'b0, ptr_q} + 4'd1);
               last_ch = !nxt[3];
               if (!last_ch) begin
                  ptr_d       = nxt[2:0];
                  frame_act_d = scan_en;
               end else if (cont && scan_en && lowest[3]) begin
                  mask_d      = ch_mask & CH_VALID;
                  ptr_d       = lowest[2:0];
                  frame_act_d = 1'b1;
               end else begin
                  frame_act_d = 1'b0;
                  hold_d      = scan_en && !cont;
               end
            end
            // The requester still holds ss_req during its own ack, so only a scan slot lets a new one in.
            if (ss_req && !cur_ss_q) begin
               cur_ss_d = 1'b1;
               cur_ch_d = ss_ch;
               state_d  = S_GAP;
            end else if (frame_act_d) begin
               cur_ss_d = 1'b0;
               cur_ch_d = ptr_d;
               state_d  = S_GAP;
            end else begin
               cur_ss_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      strt_cnv   = (state_q == S_START);
      chnnl      = cur_ch_q;
      ss_ack     = (state_q == S_STORE) && cur_ss_q;
      frame_done = (state_q == S_STORE) && !cur_ss_q && last_ch;
      busy       = (state_q != S_IDLE);
      ss_res     = ss_res_q;
      tmo_err    = tmo_err_q;
      rd_data    = rf_q[rd_ch];
   end

endmodule
